// File: rtl/mat_vec_loader_pkg.sv
// Shared definitions for the matrix/vector stream loader and the multiplier that consumes its outputs.
// Holds the loader FSM encoding and the row/column to packed-element index helper.
package mat_vec_loader_pkg;

  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    LOAD_M = 2'd1,
    FULL   = 2'd2
  } state_e;

  // Flat element index of matrix entry (r, c) in a row-major packed bus.
  function automatic int pack_idx(input int r, input int c, input int ncols);
    return r * ncols + c;
  endfunction

endpackage

// File: rtl/mat_vec_loader.sv
// Deserialises a word stream into a packed vector X followed by a row-major matrix M,
// then holds the complete set until the consumer acknowledges it.
module mat_vec_loader
  import mat_vec_loader_pkg::*;
#(
  parameter int Mdata = 4,
  parameter int Ndata = 4,
  parameter int Nbits = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [Nbits-1:0]               in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           ack,
  output logic [Mdata*Ndata*Nbits-1:0]   M,
  output logic [Ndata*Nbits-1:0]         X,
  output logic                           load_done,
  output logic                           full
);

  localparam int NumM = Mdata * Ndata;
  localparam int IdxW = $clog2(NumM + 1);
  localparam logic [IdxW-1:0] XLast = IdxW'(Ndata - 1);
  localparam logic [IdxW-1:0] MLast = IdxW'(pack_idx(Mdata - 1, Ndata - 1, Ndata));

  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic [NumM*Nbits-1:0]   m_q;
  logic [Ndata*Nbits-1:0]  x_q;
  logic                    load_done_q;
  logic                    full_q;
  logic                    xfer;

  // Ready is gated by reset so a word offered during reset is never acknowledged upstream.
  assign in_ready  = !reset && (state_q != FULL);
  assign xfer      = in_valid && in_ready;

  assign M         = m_q;
  assign X         = x_q;
  assign load_done = load_done_q;
  assign full      = full_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every branch below reads the pre-edge register values.
    if (reset) begin
      state_q     <= LOAD_X;
      idx_q       <= '0;
      // NOTE: M/X are flop arrays (not a RAM), so they get a defined reset value and the consumer never sees X.
      m_q         <= '0;
      x_q         <= '0;
      load_done_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      unique case (state_q)
        LOAD_X: begin
          if (xfer) begin
            x_q[idx_q*Nbits +: Nbits] <= in_data;
            if (idx_q == XLast) begin
              idx_q   <= '0;
              state_q <= LOAD_M;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        LOAD_M: begin
          if (xfer) begin
            m_q[idx_q*Nbits +: Nbits] <= in_data;
            if (idx_q == MLast) begin
              idx_q       <= '0;
              state_q     <= FULL;
              load_done_q <= 1'b1;
              full_q      <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (ack) begin
            state_q <= LOAD_X;
            full_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= LOAD_X;
          idx_q   <= '0;
          full_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_vec_loader.sv
// Scoreboard bench for mat_vec_loader: a word-level reference model predicts every completed set,
// a monitor checks each load_done pulse against it; a second small instance checks packing.
module tb_mat_vec_loader;

  localparam int MR = 4;
  localparam int NC = 4;
  localparam int WORDS = NC + MR * NC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ack;
  logic [127:0]      M;
  logic [31:0]       X;
  logic              load_done;
  logic              full;

  mat_vec_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ack(ack), .M(M), .X(X), .load_done(load_done), .full(full)
  );

  // Small instance: 2x3 matrix, 16-bit elements
  logic              s_reset;
  logic [15:0]       s_in_data;
  logic              s_in_valid;
  logic              s_in_ready;
  logic              s_ack;
  logic [95:0]       s_M;
  logic [47:0]       s_X;
  logic              s_load_done;
  logic              s_full;

  mat_vec_loader #(.Mdata(2), .Ndata(3), .Nbits(16)) dut_small (
    .clk(clk), .reset(s_reset), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .ack(s_ack), .M(s_M), .X(s_X), .load_done(s_load_done), .full(s_full)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: element arrays, accepted-word count, and whether a set is being held.
  logic [7:0] mx[NC];
  logic [7:0] mm[MR*NC];
  int         cnt = 0;
  bit         mfull = 1'b0;

  typedef struct {
    logic [127:0] m;
    logic [31:0]  x;
    int           cyc;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] pack_x();
    logic [31:0] v = '0;
    for (int c = 0; c < NC; c++) v[c*8 +: 8] = mx[c];
    return v;
  endfunction

  function automatic logic [127:0] pack_m();
    logic [127:0] v = '0;
    for (int r = 0; r < MR; r++)
      for (int c = 0; c < NC; c++) v[(r*NC + c)*8 +: 8] = mm[r*NC + c];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NC; i++) mx[i] = '0;
    for (int i = 0; i < MR*NC; i++) mm[i] = '0;
    cnt = 0;
    mfull = 1'b0;
  endtask

  // Sync to the falling edge and compare held state against the model.
  task automatic sync_and_check();
    @(negedge clk);
    check("full", full, mfull);
    check("X", X, pack_x());
    check("M", M, pack_m());
  endtask

  // Drive one cycle of inputs, check ready, and advance the model as if the edge happened.
  task automatic drive(input bit v, input logic [7:0] d, input bit a, input bit r);
    in_valid = v;
    in_data  = d;
    ack      = a;
    reset    = r;
    #1;
    check("in_ready", in_ready, !r && !mfull);
    if (r) begin
      model_clear();
    end else if (mfull) begin
      if (a) mfull = 1'b0;
    end else if (v) begin
      if (cnt < NC) mx[cnt] = d;
      else mm[cnt - NC] = d;
      cnt++;
      if (cnt == WORDS) begin
        cnt = 0;
        mfull = 1'b1;
        exp_q.push_back('{m: pack_m(), x: pack_x(), cyc: cyc + 1});
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit a, input bit r);
    sync_and_check();
    drive(v, d, a, r);
  endtask

  function automatic logic [7:0] word(input int k);
    return (k < NC) ? 8'(k + 1) : 8'(k - NC + 1);
  endfunction

  // Monitor: every load_done pulse must match the oldest predicted set, on the predicted cycle.
  always @(negedge clk) begin
    if (load_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL load_done: pulse at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("load_done_cycle", 128'(cyc), 128'(e.cyc));
        check("done_M", M, e.m);
        check("done_X", 128'(X), 128'(e.x));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int guard;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; ack = 1'b0;
    s_reset = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_ack = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);

    // Reset state, ready low while reset held
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Directed stream X=1..4, M=1..16, continuous valid, ack held low
    for (int i = 0; i < WORDS; i++) step(1'b1, word(i), 1'b0, 1'b0);
    sync_and_check();
    check("X_const", 128'(X), 128'h04030201);
    check("M_low", 128'(M[7:0]), 128'h01);
    check("M_high", 128'(M[127:120]), 128'h10);
    check("done_const", 128'(load_done), 128'h1);
    drive(1'b1, 8'hEE, 1'b0, 1'b0);

    // Hold in FULL for 10 cycles with valid offered, then release with a concurrent word
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    step(1'b1, 8'hAB, 1'b0, 1'b0);
    sync_and_check();
    check("first_after_ack", 128'(X[7:0]), 128'hAB);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Same data with 50% valid bubbles, starting from a clean set
    step(1'b0, 8'h00, 1'b0, 1'b1);
    k = 0;
    guard = 0;
    while (k < WORDS && guard < 400) begin
      bit v;
      v = 1'($urandom_range(1));
      step(v, v ? word(k) : 8'($urandom), 1'b0, 1'b0);
      if (v) k++;
      guard++;
    end
    check("bubble_words_done", 128'(k), 128'(WORDS));
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset after 7 accepted words (with a word offered on the reset cycle), then a fresh stream
    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < WORDS; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random valid, random data, random ack (including ack outside FULL)
    for (int i = 0; i < 150; i++)
      step($urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < 30, 1'b0);

    // ack tied high, valid continuous: two sets back to back
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 2 * (WORDS + 1) + 2; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    sync_and_check();
    check("pending_sets", 128'(exp_q.size()), 128'h0);

    // Small instance: 9 words, packing of X and M
    @(negedge clk);
    s_reset = 1'b0;
    s_in_valid = 1'b1;
    for (int w = 0; w < 9; w++) begin
      s_in_data = 16'hA000 + 16'(w);
      @(negedge clk);
      if (w < 8) check("s_no_done", 128'(s_load_done), 128'h0);
    end
    s_in_valid = 1'b0;
    check("s_done", 128'(s_load_done), 128'h1);
    check("s_full", 128'(s_full), 128'h1);
    check("s_ready", 128'(s_in_ready), 128'h0);
    for (int c = 0; c < 3; c++)
      check("s_X_elem", 128'(s_X[c*16 +: 16]), 128'(16'hA000 + 16'(c)));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        check("s_M_elem", 128'(s_M[(r*3 + c)*16 +: 16]), 128'(16'hA003 + 16'(r*3 + c)));
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0;
    check("s_full_released", 128'(s_full), 128'h0);
    check("s_ready_released", 128'(s_in_ready), 128'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
